// File: rtl/alu_pkg.sv
// Shared definitions for the two-channel ALU arbiter.
//   - ALU opcode encodings (OP_ADD .. OP_XOR); codes above OP_XOR are illegal.
//   - Arbiter FSM state encoding (ST_IDLE, ST_EXEC, ST_HOLD).
//   - is_legal_op(): 1 when an opcode is one the ALU implements.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 4;
    localparam int unsigned ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU.
// Ports:
//   a_i, b_i  operands
//   op_i      opcode (see alu_pkg)
//   y_o       result
//   carry_o   carry out for ADD, borrow for SUB, 0 otherwise
// Illegal opcodes produce y_o = 0, carry_o = 0.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [2:0] op_i,
    output logic [3:0] y_o,
    output logic       carry_o
);

    logic [4:0] wide;

    always_comb begin
        wide    = 5'd0;
        y_o     = 4'd0;
        carry_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide    = {1'b0, a_i} + {1'b0, b_i};
                y_o     = wide[3:0];
                carry_o = wide[4];
            end
            OP_SUB: begin
                // Bit 4 of the zero-extended difference is the borrow.
                wide    = {1'b0, a_i} - {1'b0, b_i};
                y_o     = wide[3:0];
                carry_o = wide[4];
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_2ch.sv
// Two-channel round-robin front end for a single alu_4bit.
// Each accepted request is captured, evaluated for one cycle (EXEC), and
// returned as a registered response held until the consumer accepts it.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/op       requester N handshake and payload (N = 0, 1)
//   rsp_valid/ready               response handshake
//   rsp_y, rsp_carry, rsp_err     result, carry/borrow, illegal-opcode flag
//   rsp_id                        requester that issued the response
//   busy                          FSM is not idle
// DATA_W and OP_W are fixed by alu_4bit; other values are not supported.
module alu_arbiter_2ch
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_carry,
    output logic              rsp_id,
    output logic              rsp_err,

    output logic              busy
);

    state_e state_q, state_d;

    logic              last_grant_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [OP_W-1:0]   opc_q;
    logic              opid_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_y_q;
    logic              rsp_carry_q;
    logic              rsp_id_q;
    logic              rsp_err_q;

    logic              grant_valid;
    logic              grant_id;

    logic [DATA_W-1:0] alu_y;
    logic              alu_carry;
    logic              op_legal;
    logic [DATA_W-1:0] res_y;
    logic              res_carry;

    alu_4bit u_alu (
        .a_i     (opa_q),
        .b_i     (opb_q),
        .op_i    (opc_q),
        .y_o     (alu_y),
        .carry_o (alu_carry)
    );

    // Illegal opcodes force a clean zero result regardless of the ALU output.
    always_comb begin
        op_legal  = is_legal_op(opc_q);
        res_y     = op_legal ? alu_y : '0;
        res_carry = op_legal ? alu_carry : 1'b0;
    end

    // Next-state and grant. The rst_n term keeps both readies low during reset.
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    grant_valid = 1'b1;
                    // On contention, favour the channel that did not win last.
                    grant_id    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_HOLD;
            ST_HOLD: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req0_ready = grant_valid & ~grant_id;
        req1_ready = grant_valid & grant_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            opid_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_y_q      <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_valid) begin
                last_grant_q <= grant_id;
                opid_q       <= grant_id;
                opa_q        <= grant_id ? req1_a  : req0_a;
                opb_q        <= grant_id ? req1_b  : req0_b;
                opc_q        <= grant_id ? req1_op : req0_op;
            end
            if (state_q == ST_EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_y_q     <= res_y;
                rsp_carry_q <= res_carry;
                rsp_id_q    <= opid_q;
                rsp_err_q   <= ~op_legal;
            end else if (state_q == ST_HOLD && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
